// File: rtl/sdram_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bus_monitor
// Purpose  : Sits between an SDRAM controller's pins and the SDRAM model(s).
//            Delays the command/address pin set by DLY_CYC clocks and tracks
//            per-chip-select, per-bank state to flag protocol/timing
//            violations (tRCD, tRP, tRAS, bank-state misuse, CS conflicts).
// Ports    : clk_i, rst_n_i (sync, active-low)
//            addr_i/ba_i/cs_n_i/ras_i/cas_i/we_i/cke_i/dqm_i  controller pins
//            addr_o/ba_o/cs_n_o/ras_o/cas_o/we_o/cke_o/dqm_o  delayed pins
//            err_o (pulse), err_code_o/err_cs_o/err_bank_o (last violation),
//            err_sticky_o, cmd_cnt_o (non-NOP commands, wraps)
// Option   : SDRAM_MON_STATS_EN adds rd_cnt_o, wr_cnt_o, ref_cnt_o.
// Revision : 1.0  initial release
// ============================================================================
module sdram_bus_monitor #(
    parameter int ADDR_BITS = 12,
    parameter int BA_BITS   = 2,
    parameter int NUM_CS    = 1,
    parameter int DQM_BITS  = 2,
    parameter int DLY_CYC   = 1,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RAS     = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [ADDR_BITS-1:0]   addr_i,
    input  logic [BA_BITS-1:0]     ba_i,
    input  logic [NUM_CS-1:0]      cs_n_i,
    input  logic                   ras_i,
    input  logic                   cas_i,
    input  logic                   we_i,
    input  logic                   cke_i,
    input  logic [DQM_BITS-1:0]    dqm_i,
    output logic [ADDR_BITS-1:0]   addr_o,
    output logic [BA_BITS-1:0]     ba_o,
    output logic [NUM_CS-1:0]      cs_n_o,
    output logic                   ras_o,
    output logic                   cas_o,
    output logic                   we_o,
    output logic                   cke_o,
    output logic [DQM_BITS-1:0]    dqm_o,
    output logic                   err_o,
    output logic [2:0]             err_code_o,
    output logic [$clog2(NUM_CS):0] err_cs_o,
    output logic [BA_BITS-1:0]     err_bank_o,
    output logic                   err_sticky_o,
    output logic [31:0]            cmd_cnt_o
`ifdef SDRAM_MON_STATS_EN
    ,
    output logic [31:0]            rd_cnt_o,
    output logic [31:0]            wr_cnt_o,
    output logic [31:0]            ref_cnt_o
`endif
);

    localparam int NB    = 1 << BA_BITS;
    localparam int CSW   = $clog2(NUM_CS) + 1;
    localparam int T_MAX = (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                                           : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int TW    = $clog2(T_MAX) + 1;
    localparam int PW    = ADDR_BITS + BA_BITS + NUM_CS + 4 + DQM_BITS;

    // Pin vector order: addr, ba, cs_n, ras, cas, we, cke, dqm
    localparam logic [PW-1:0] PIN_NOP = {{(ADDR_BITS + BA_BITS){1'b0}}, {NUM_CS{1'b1}},
                                         3'b111, {(1 + DQM_BITS){1'b0}}};

    localparam logic [TW-1:0] RCD_LAST = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RP_LAST  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RAS_MIN  = TW'(T_RAS);

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    typedef enum logic [1:0] {
        BK_IDLE        = 2'd0,
        BK_ACTIVATING  = 2'd1,
        BK_ACTIVE      = 2'd2,
        BK_PRECHARGING = 2'd3
    } bank_state_e;

    // ------------------------------------------------------------------
    // Pin pipeline (independent of the checker)
    // ------------------------------------------------------------------
    logic [PW-1:0] pin_in;
    logic [PW-1:0] pin_out;

    assign pin_in = {addr_i, ba_i, cs_n_i, ras_i, cas_i, we_i, cke_i, dqm_i};

    generate
        if (DLY_CYC == 0) begin : g_passthru
            assign pin_out = pin_in;
        end else begin : g_pipe
            logic [PW-1:0] pipe_q [DLY_CYC];
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < DLY_CYC; i++) pipe_q[i] <= PIN_NOP;
                end else begin
                    pipe_q[0] <= pin_in;
                    for (int i = 1; i < DLY_CYC; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign pin_out = pipe_q[DLY_CYC-1];
        end
    endgenerate

    assign {addr_o, ba_o, cs_n_o, ras_o, cas_o, we_o, cke_o, dqm_o} = pin_out;

    // ------------------------------------------------------------------
    // Command decode on the undelayed pins
    // ------------------------------------------------------------------
    logic [CSW-1:0] cs_low_cnt;
    logic [CSW-1:0] cs_sel;
    logic [2:0]     cmd;
    logic           cs_multi;
    logic           cmd_valid;

    // Descending scan leaves cs_sel at the lowest asserted chip select.
    always_comb begin
        cs_low_cnt = '0;
        cs_sel     = '0;
        for (int c = NUM_CS - 1; c >= 0; c--) begin
            if (!cs_n_i[c]) begin
                cs_low_cnt = cs_low_cnt + 1'b1;
                cs_sel     = CSW'(c);
            end
        end
    end

    assign cmd       = {ras_i, cas_i, we_i};
    assign cs_multi  = cke_i && (cs_low_cnt > CSW'(1));
    assign cmd_valid = cke_i && (cs_low_cnt == CSW'(1));

    // ------------------------------------------------------------------
    // Bank state and violation detection
    // ------------------------------------------------------------------
    bank_state_e   bank_q [NUM_CS][NB];
    logic [TW-1:0] tmr_q  [NUM_CS][NB];   // cycles spent in ACTIVATING/PRECHARGING
    logic [TW-1:0] ras_q  [NUM_CS][NB];   // cycles since ACT, saturating at T_RAS
    logic          tgt    [NUM_CS][NB];

    // A bank is targeted by the decoded command if it is on the selected CS and
    // either matches ba_i or the command is a precharge-all.
    always_comb begin
        for (int c = 0; c < NUM_CS; c++) begin
            for (int b = 0; b < NB; b++) begin
                tgt[c][b] = cmd_valid && (CSW'(c) == cs_sel) &&
                            (((cmd == CMD_PRE) && addr_i[10]) || (BA_BITS'(b) == ba_i));
            end
        end
    end

    logic [2:0]         err_code_d;
    logic [BA_BITS-1:0] err_bank_d;
    logic [2:0]         bank_code;

    // Descending bank scan so the lowest violating bank is the one reported.
    always_comb begin
        err_code_d = 3'd0;
        err_bank_d = ba_i;
        bank_code  = 3'd0;
        if (cs_multi) begin
            err_code_d = 3'd7;
        end else if (cmd_valid) begin
            for (int c = 0; c < NUM_CS; c++) begin
                for (int b = NB - 1; b >= 0; b--) begin
                    bank_code = 3'd0;
                    if (CSW'(c) == cs_sel) begin
                        case (cmd)
                            CMD_REF, CMD_MRS: begin
                                if (bank_q[c][b] != BK_IDLE) bank_code = 3'd5;
                            end
                            CMD_ACT: begin
                                if (tgt[c][b]) begin
                                    if (bank_q[c][b] == BK_PRECHARGING)  bank_code = 3'd6;
                                    else if (bank_q[c][b] != BK_IDLE)    bank_code = 3'd1;
                                end
                            end
                            CMD_RD, CMD_WR: begin
                                if (tgt[c][b]) begin
                                    case (bank_q[c][b])
                                        BK_IDLE:        bank_code = 3'd2;
                                        BK_ACTIVATING:  bank_code = 3'd3;
                                        BK_PRECHARGING: bank_code = 3'd6;
                                        default:        bank_code = 3'd0;
                                    endcase
                                end
                            end
                            CMD_PRE: begin
                                if (tgt[c][b]) begin
                                    if (bank_q[c][b] == BK_PRECHARGING)
                                        bank_code = 3'd6;
                                    else if ((bank_q[c][b] != BK_IDLE) && (ras_q[c][b] < RAS_MIN))
                                        bank_code = 3'd4;
                                end
                            end
                            default: bank_code = 3'd0;
                        endcase
                    end
                    if (bank_code != 3'd0) begin
                        err_code_d = bank_code;
                        err_bank_d = BA_BITS'(b);
                    end
                end
            end
        end
    end

    // Bank FSMs. Offending commands still move the FSM, mirroring what the
    // DRAM model itself would do with them.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NUM_CS; c++) begin
                for (int b = 0; b < NB; b++) begin
                    bank_q[c][b] <= BK_IDLE;
                    tmr_q[c][b]  <= '0;
                    ras_q[c][b]  <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CS; c++) begin
                for (int b = 0; b < NB; b++) begin
                    if (ras_q[c][b] != RAS_MIN) ras_q[c][b] <= ras_q[c][b] + 1'b1;
                    case (bank_q[c][b])
                        BK_ACTIVATING: begin
                            if (tmr_q[c][b] >= RCD_LAST) bank_q[c][b] <= BK_ACTIVE;
                            else                         tmr_q[c][b]  <= tmr_q[c][b] + 1'b1;
                        end
                        BK_PRECHARGING: begin
                            if (tmr_q[c][b] >= RP_LAST) bank_q[c][b] <= BK_IDLE;
                            else                        tmr_q[c][b]  <= tmr_q[c][b] + 1'b1;
                        end
                        default: ;
                    endcase
                    if (tgt[c][b] && (cmd == CMD_ACT)) begin
                        bank_q[c][b] <= (T_RCD > 1) ? BK_ACTIVATING : BK_ACTIVE;
                        tmr_q[c][b]  <= TW'(1);
                        ras_q[c][b]  <= TW'(1);
                    end else if (tgt[c][b] && (cmd == CMD_PRE) && (bank_q[c][b] != BK_IDLE)) begin
                        bank_q[c][b] <= (T_RP > 1) ? BK_PRECHARGING : BK_IDLE;
                        tmr_q[c][b]  <= TW'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered status outputs
    // ------------------------------------------------------------------
    logic               err_q;
    logic [2:0]         err_code_q;
    logic [CSW-1:0]     err_cs_q;
    logic [BA_BITS-1:0] err_bank_q;
    logic               err_sticky_q;
    logic [31:0]        cmd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            err_cs_q     <= '0;
            err_bank_q   <= '0;
            err_sticky_q <= 1'b0;
            cmd_cnt_q    <= '0;
        end else begin
            err_q <= (err_code_d != 3'd0);
            if (err_code_d != 3'd0) begin
                err_code_q   <= err_code_d;
                err_cs_q     <= cs_sel;
                err_bank_q   <= err_bank_d;
                err_sticky_q <= 1'b1;
            end
            if (cmd_valid && (cmd != CMD_NOP)) cmd_cnt_q <= cmd_cnt_q + 32'd1;
        end
    end

    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign err_cs_o     = err_cs_q;
    assign err_bank_o   = err_bank_q;
    assign err_sticky_o = err_sticky_q;
    assign cmd_cnt_o    = cmd_cnt_q;

`ifdef SDRAM_MON_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] ref_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            ref_cnt_q <= '0;
        end else if (cmd_valid) begin
            if (cmd == CMD_RD)  rd_cnt_q  <= rd_cnt_q + 32'd1;
            if (cmd == CMD_WR)  wr_cnt_q  <= wr_cnt_q + 32'd1;
            if (cmd == CMD_REF) ref_cnt_q <= ref_cnt_q + 32'd1;
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign ref_cnt_o = ref_cnt_q;
`endif

endmodule
`default_nettype wire
